serial_deshifter: RTL
=====================

Name: serial_deshifter

Overview:
- Serial-in, parallel-out counterpart to the 4-bit left/right combinational shifter.
- Collects a serial bit stream into WIDTH-bit words, shifting left (MSB-first) or right (LSB-first).
- Double-buffered: an internal shift register assembles the next word while the previous word waits in an output register under a valid/ready handshake.
- Sits between a 1-bit serial source and a parallel word consumer.

Parameters:
WIDTH, 4, word width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock
- nrst  input  1  synchronous active-low reset
- sin  input  1  serial data bit
- sin_valid  input  1  sin is sampled this cycle
- dir  input  1  0 = shift left (bit enters at bit 0, MSB-first); 1 = shift right (bit enters at bit WIDTH-1, LSB-first)
- clear  input  1  synchronous flush of partial word, output word and overrun
- o  output  WIDTH  completed word
- o_valid  output  1  o holds an unconsumed word
- o_ready  input  1  consumer accepts o this cycle
- busy  output  1  partial word in progress (bit count != 0)
- overrun  output  1  sticky: a completed word was dropped

Behaviour:
- Reset: on a clk edge with nrst=0, all state clears. o=0, o_valid=0, busy=0, overrun=0, shift register=0, bit count=0, latched direction=0. Reset has priority over everything.
- clear=1 (nrst=1): same effect as reset on the next edge. sin_valid in that cycle is ignored. Priority is below reset and above all other events.
- Internal state:
  - shreg[WIDTH-1:0]
  - cnt, width clog2(WIDTH+1), range 0..WIDTH-1
  - ldir (latched direction)
  - output register o, o_valid, overrun
- Shifting on sin_valid=1:
  - Left: shreg <= {shreg[WIDTH-2:0], sin}.
  - Right: shreg <= {sin, shreg[WIDTH-1:1]}.
  - The shift uses dir when cnt==0 and latches it into ldir. Bits with cnt>0 use ldir, so dir changes mid-word are ignored.
- cnt increments per accepted bit. The accepted bit with cnt==WIDTH-1 completes the word and returns cnt to 0.
- busy = (cnt != 0), combinational from the registered count.
- Completion: the completed value (shreg after including the final bit) goes to o on the same edge.
  - o_valid=1 is visible the cycle after the last bit is sampled (latency 1).
  - The shift register is free immediately, with no gap between words.
- Handshake:
  - o_valid stays 1 and o stays stable until a cycle with o_valid=1 and o_ready=1.
  - On that edge o_valid drops to 0, unless a word completes on the same edge.
  - o_ready while o_valid=0 has no effect.
- Simultaneous completion and consume (o_valid=1, o_ready=1, word completes): the new word loads into o and o_valid stays 1. No overrun.
- Completion while full (o_valid=1, o_ready=0): the new word is discarded and o is kept. overrun <= 1 and stays set until clear or reset. cnt still returns to 0.
- sin_valid=0: no shift, cnt holds; gaps of any length between bits are allowed.
- States, derived from (cnt, o_valid):
  - EMPTY: cnt=0, !o_valid
  - FILLING: cnt>0, !o_valid
  - HELD: cnt=0, o_valid
  - HELD_FILLING: cnt>0, o_valid
  - Transitions follow the rules above.
  - The implementation may use an explicit FSM, but the outputs must match.
- Bit order and o contents never depend on o_ready timing.

Test Plan:
1. Left assemble: reset, dir=0, sin_valid=1 for 4 cycles with sin=1,0,1,1, o_ready=0. Required: shreg steps 0001,0010,0101,1011. o=4'b1011 and o_valid=1 one cycle after the 4th bit; busy=1 during bits 2-4 and 0 afterwards.
2. Right assemble: dir=1, sin=1,0,1,1. Required: o=4'b1101, o_valid=1. Toggling dir to 0 after the first bit still gives 4'b1101.
3. Back-to-back with consume: stream 8 contiguous bits 1,0,1,1,0,1,1,0 (dir=0), with o_ready=1 on the cycle the second word completes. Required: first o=4'b1011, then o=4'b0110; o_valid stays 1 continuously and overrun=0.
4. Overrun: same 8 bits with o_ready held 0. Required: o stays 4'b1011, overrun=1 after the 8th bit. A following clear gives o_valid=0, overrun=0, busy=0.
5. Gaps and mid-word reset: sin_valid pattern 1,0,0,1 (2 bits accepted, busy=1), then nrst=0 for 1 cycle. Required: o=0, o_valid=0, busy=0. A fresh 4-bit sequence 0,0,0,1 (dir=0) then yields o=4'b0001.
6. clear vs sin_valid same cycle, mid-word at cnt=3: required: bit ignored, cnt=0, no word produced. The next 4 bits form a complete word.

Source files
------------

// File: rtl/serial_deshifter.sv
// rtl/serial_deshifter.sv - serial-in parallel-out word assembler with a double-buffered output
module serial_deshifter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             dir,
    input  logic             clear,
    output logic [WIDTH-1:0] o,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             ldir;

    logic             eff_dir;
    logic [WIDTH-1:0] shifted;
    logic             complete;
    logic             consume;

    // Direction is fixed by the first bit of each word; later dir changes are ignored.
    always_comb begin
        eff_dir  = (cnt == '0) ? dir : ldir;
        shifted  = eff_dir ? {sin, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], sin};
        complete = sin_valid && (cnt == LAST);
        consume  = o_valid && o_ready;
    end

    assign busy = (cnt != '0);

    always_ff @(posedge clk) begin
        if (!nrst || clear) begin
            shreg   <= '0;
            cnt     <= '0;
            ldir    <= 1'b0;
            o       <= '0;
            o_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (sin_valid) begin
                if (cnt == '0) begin
                    ldir <= dir;
                end
                shreg <= shifted;
                cnt   <= complete ? '0 : cnt + CW'(1);
            end

            // A completing word may refill o on the same edge it is consumed.
            if (complete) begin
                if (!o_valid || o_ready) begin
                    o       <= shifted;
                    o_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (consume) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
